// File: rtl/sram_rw_port_arbiter.sv
// Two-requester arbiter for the read/write port of the 32x256 OpenRAM macro.
// Fixed priority to m0, with a starvation limiter for m1 and a fixed-latency read return path.
module sram_rw_port_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 32,
    parameter int BURST_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [3:0]    m0_wmask,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [3:0]    m1_wmask,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic          csb0,
    output logic          web0,
    output logic [3:0]    wmask0,
    output logic [AW-1:0] addr0,
    output logic [DW-1:0] din0,
    input  logic [DW-1:0] dout0
);

    logic [3:0]    starve_cnt_r;
    logic          m0_win_s;
    logic          m1_win_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdata_s;
    logic [3:0]    sel_wmask_s;

    logic          iss_rd_r;
    logic          iss_id_r;
    logic          s1_rd_r;
    logic          s1_id_r;

    // Grant decision: m1 wins when m0 is idle or m1 has waited BURST_LIMIT m0 grants.
    always_comb begin
        m0_win_s = 1'b0;
        m1_win_s = 1'b0;
        if (rst) begin
            m0_win_s = 1'b0;
            m1_win_s = 1'b0;
        end else if (m1_req && (!m0_req || (starve_cnt_r == 4'(BURST_LIMIT)))) begin
            m1_win_s = 1'b1;
        end else if (m0_req) begin
            m0_win_s = 1'b1;
        end else begin
            m0_win_s = 1'b0;
            m1_win_s = 1'b0;
        end
    end

    assign m0_gnt = m0_win_s;
    assign m1_gnt = m1_win_s;

    // Winner's command fields
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        sel_wmask_s = 4'h0;
        if (m1_win_s) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
            sel_wmask_s = m1_wmask;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
            sel_wmask_s = m0_wmask;
        end
    end

    // Starvation counter: counts m0 grants taken while m1 is waiting, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else if (!m1_req || m1_win_s) begin
            starve_cnt_r <= 4'd0;
        end else if (m0_win_s && (starve_cnt_r != 4'hF)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Issue stage: registered macro command; address and data hold while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            csb0     <= 1'b1;
            web0     <= 1'b1;
            wmask0   <= 4'h0;
            addr0    <= '0;
            din0     <= '0;
            iss_rd_r <= 1'b0;
            iss_id_r <= 1'b0;
        end else if (m0_win_s || m1_win_s) begin
            csb0     <= 1'b0;
            web0     <= !sel_we_s;
            wmask0   <= sel_we_s ? sel_wmask_s : 4'h0;
            addr0    <= sel_addr_s;
            din0     <= sel_wdata_s;
            iss_rd_r <= !sel_we_s;
            iss_id_r <= m1_win_s;
        end else begin
            csb0     <= 1'b1;
            web0     <= 1'b1;
            wmask0   <= 4'h0;
            addr0    <= addr0;
            din0     <= din0;
            iss_rd_r <= 1'b0;
            iss_id_r <= iss_id_r;
        end
    end

    // Macro-access stage: tracks the read the macro is performing this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_rd_r <= 1'b0;
            s1_id_r <= 1'b0;
        end else begin
            s1_rd_r <= iss_rd_r;
            s1_id_r <= iss_id_r;
        end
    end

    // Return stage: capture dout0 into the owning requester's data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= s1_rd_r && !s1_id_r;
            m1_rvalid <= s1_rd_r && s1_id_r;
            if (s1_rd_r && !s1_id_r) begin
                m0_rdata <= dout0;
            end else begin
                m0_rdata <= m0_rdata;
            end
            if (s1_rd_r && s1_id_r) begin
                m1_rdata <= dout0;
            end else begin
                m1_rdata <= m1_rdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural model of the OpenRAM port.
module tb_sram_rw_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [7:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic [3:0]  m0_wmask;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [3:0]  m1_wmask;
    logic        csb0, web0;
    logic [3:0]  wmask0;
    logic [7:0]  addr0;
    logic [31:0] din0, dout0;

    int checks;
    int failures;

    logic [31:0] mem [0:255];

    sram_rw_port_arbiter #(.AW(8), .DW(32), .BURST_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wmask(m0_wmask), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wmask(m1_wmask), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: inputs sampled on the rising edge, read data valid after that edge.
    always @(posedge clk) begin
        if (!csb0) begin
            if (!web0) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask0[b]) mem[addr0][8*b +: 8] = din0[8*b +: 8];
                end
            end else begin
                dout0 <= mem[addr0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic req, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; m0_wmask = m;
    endtask

    task automatic drv1(input logic req, input logic we, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] m);
        m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_wmask = m;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        dout0 = 32'h0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        rst = 1'b1;
        drv0(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
        drv1(1'b1, 1'b0, 8'h00, 32'h0, 4'h0);

        // Reset: two clocks with rst high, requests present
        step(); step(); #1;
        chk("rst_csb0", 32'(csb0), 32'h1);
        chk("rst_web0", 32'(web0), 32'h1);
        chk("rst_wmask0", 32'(wmask0), 32'h0);
        chk("rst_addr0", 32'(addr0), 32'h0);
        chk("rst_din0", din0, 32'h0);
        chk("rst_m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_m1_rdata", m1_rdata, 32'h0);
        rst = 1'b0;
        drv0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drv1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);

        // Pipelined m1 reads of 0x00..0x07 on consecutive cycles
        for (int s = 0; s < 12; s++) begin
            step();
            if (s < 8) drv1(1'b1, 1'b0, 8'(s), 32'h0, 4'h0);
            else       drv1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
            #1;
            if (s < 8) chk("pipe_m1_gnt", 32'(m1_gnt), 32'h1);
            if (s >= 3 && s < 11) begin
                chk("pipe_m1_rvalid", 32'(m1_rvalid), 32'h1);
                chk("pipe_m1_rdata", m1_rdata, 32'hC0DE_0000 + 32'(s - 3));
            end else begin
                chk("pipe_m1_rvalid_idle", 32'(m1_rvalid), 32'h0);
            end
            chk("pipe_m0_rvalid", 32'(m0_rvalid), 32'h0);
        end

        // m0 write 0x05 then read back
        step(); drv0(1'b1, 1'b1, 8'h05, 32'hDEAD_BEEF, 4'hF); #1;
        chk("wr_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("wr_m1_gnt", 32'(m1_gnt), 32'h0);
        step(); drv0(1'b1, 1'b0, 8'h05, 32'h0, 4'h0); #1;
        chk("rd_m0_gnt", 32'(m0_gnt), 32'h1);
        chk("wr_csb0", 32'(csb0), 32'h0);
        chk("wr_web0", 32'(web0), 32'h0);
        chk("wr_addr0", 32'(addr0), 32'h05);
        chk("wr_din0", din0, 32'hDEAD_BEEF);
        chk("wr_wmask0", 32'(wmask0), 32'hF);
        step(); drv0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0); #1;
        chk("rd_csb0", 32'(csb0), 32'h0);
        chk("rd_web0", 32'(web0), 32'h1);
        chk("rd_wmask0", 32'(wmask0), 32'h0);
        chk("rd_rvalid_early", 32'(m0_rvalid), 32'h0);
        step(); #1;
        chk("rd_rvalid_early2", 32'(m0_rvalid), 32'h0);
        chk("idle_csb0", 32'(csb0), 32'h1);
        chk("idle_addr0_hold", 32'(addr0), 32'h05);
        step(); #1;
        chk("rd_rvalid", 32'(m0_rvalid), 32'h1);
        chk("rd_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_rvalid", 32'(m1_rvalid), 32'h0);
        step(); #1;
        chk("rd_rvalid_pulse", 32'(m0_rvalid), 32'h0);
        chk("rd_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

        // Byte mask: full write, masked write of byte 1, read back
        step(); drv0(1'b1, 1'b1, 8'h10, 32'h1122_3344, 4'hF); #1;
        chk("mask_w1_gnt", 32'(m0_gnt), 32'h1);
        step(); drv0(1'b1, 1'b1, 8'h10, 32'hAABB_CCDD, 4'h2); #1;
        chk("mask_w2_gnt", 32'(m0_gnt), 32'h1);
        step(); drv0(1'b1, 1'b0, 8'h10, 32'h0, 4'h0); #1;
        chk("mask_rd_gnt", 32'(m0_gnt), 32'h1);
        step(); drv0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0); #1;
        chk("mask_no_wr_rvalid1", 32'(m0_rvalid), 32'h0);
        step(); #1;
        chk("mask_no_wr_rvalid2", 32'(m0_rvalid), 32'h0);
        step(); #1;
        chk("mask_rvalid", 32'(m0_rvalid), 32'h1);
        chk("mask_rdata", m0_rdata, 32'h1122_CC44);

        // Starvation limiter: both requesting continuously
        for (int s = 0; s < 10; s++) begin
            step();
            drv0(1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
            drv1(1'b1, 1'b0, 8'h21, 32'h0, 4'h0);
            #1;
            chk("starve_m0_gnt", 32'(m0_gnt), (s % 5 == 4) ? 32'h0 : 32'h1);
            chk("starve_m1_gnt", 32'(m1_gnt), (s % 5 == 4) ? 32'h1 : 32'h0);
        end
        step();
        drv0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drv1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        step(); step(); step(); step();

        // Reset one cycle after a read grant drops the read
        step(); drv0(1'b1, 1'b0, 8'h10, 32'h0, 4'h0); #1;
        chk("rstmid_gnt", 32'(m0_gnt), 32'h1);
        step(); drv0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        drv1(1'b1, 1'b0, 8'h00, 32'h0, 4'h0); rst = 1'b1; #1;
        chk("rstmid_m1_gnt_in_rst", 32'(m1_gnt), 32'h0);
        step(); rst = 1'b0; drv1(1'b0, 1'b0, 8'h00, 32'h0, 4'h0); #1;
        chk("rstmid_csb0", 32'(csb0), 32'h1);
        chk("rstmid_rvalid0", 32'(m0_rvalid), 32'h0);
        chk("rstmid_rdata_clr", m0_rdata, 32'h0);
        chk("rstmid_m1_rdata_clr", m1_rdata, 32'h0);
        step(); #1;
        chk("rstmid_rvalid1", 32'(m0_rvalid), 32'h0);
        step(); #1;
        chk("rstmid_rvalid2", 32'(m0_rvalid), 32'h0);
        step(); drv0(1'b1, 1'b0, 8'h10, 32'h0, 4'h0); #1;
        chk("post_rst_gnt", 32'(m0_gnt), 32'h1);
        step(); drv0(1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
        step(); step(); #1;
        chk("post_rst_rvalid", 32'(m0_rvalid), 32'h1);
        chk("post_rst_rdata", m0_rdata, 32'h1122_CC44);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
